// File: rtl/req_ack_rr_arbiter_if.sv
// Requester-side valid/ready/data channels and the registered output port of the
// round-robin arbiter that feeds req_ack_synch.
interface req_ack_rr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic [NUM_REQ-1:0]            i_valid;
  logic [NUM_REQ-1:0]            o_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
  logic                          o_valid;
  logic                          i_ready;
  logic [DATA_WIDTH-1:0]         o_data;
  logic [ID_WIDTH-1:0]           o_id;
  logic [CNT_WIDTH-1:0]          o_xfer_cnt;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_id, o_xfer_cnt
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_id, o_xfer_cnt
  );
endinterface

// File: rtl/req_ack_rr_arbiter.sv
// Round-robin arbiter: grants one requester at a time into a single registered
// output word (with requester id) and counts completed downstream transfers.
module req_ack_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  req_ack_rr_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  gnt_found;
  int unsigned           gnt_int;
  int unsigned           cand;
  logic [NUM_REQ-1:0]    ready;

  // Search starts one past the last granted index so the last winner is tried last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_int   = 0;
    cand      = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(last_q) + off) % NUM_REQ;
      if (!gnt_found && bus.i_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_int   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ready   = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          ready[gnt_int] = 1'b1;
          state_d        = HOLD;
          data_d         = bus.i_data[gnt_int*DATA_WIDTH +: DATA_WIDTH];
          id_d           = ID_WIDTH'(gnt_int);
          last_d         = ID_WIDTH'(gnt_int);
        end
      end
      HOLD: begin
        if (bus.i_ready) begin
          state_d = IDLE;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Suppress the handshake during reset so no requester sees a phantom accept.
  assign bus.o_ready    = i_rst ? '0 : ready;
  assign bus.o_valid    = (state_q == HOLD);
  assign bus.o_data     = data_q;
  assign bus.o_id       = id_q;
  assign bus.o_xfer_cnt = cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      last_q  <= ID_WIDTH'(NUM_REQ - 1);
      id_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
